// File: rtl/clock_divider_sequencer.sv
// clock_divider_sequencer: run-time programmable clock divider with start/stop/burst sequencing
module clock_divider_sequencer #(
    parameter int WIDTH       = 8,
    parameter int CNT_WIDTH   = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     cfg_div,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] burst_len,
    output logic                 out_clk,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     active_div
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     count_q;
    logic [WIDTH-1:0]     active_div_q;
    logic [WIDTH-1:0]     pend_div_q;
    logic                 pending_q;
    logic                 out_clk_q;
    logic                 done_q;
    logic [CNT_WIDTH-1:0] burst_rem_q;
    logic                 cfg_acc;
    logic                 toggle;
    logic                 boundary;
    logic [WIDTH-1:0]     cfg_clamped;

    assign cfg_ready   = (state_q == IDLE) || !pending_q;
    assign cfg_acc     = cfg_valid && cfg_ready;
    assign cfg_clamped = (cfg_div == '0) ? WIDTH'(1) : cfg_div;
    assign toggle      = count_q == active_div_q - 1'b1;
    assign boundary    = toggle && out_clk_q;

    assign out_clk    = out_clk_q;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign active_div = active_div_q;

    // Sequencer: phase counting, start/stop/drain control, burst tracking and ratio hand-over at period boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            active_div_q <= WIDTH'(DEFAULT_DIV);
            pend_div_q   <= '0;
            pending_q    <= 1'b0;
            out_clk_q    <= 1'b0;
            done_q       <= 1'b0;
            burst_rem_q  <= '0;
        end else begin
            done_q <= 1'b0;
            // A config arriving while busy waits; pending is only cleared below when it was already set,
            // and cfg_ready is low then, so a new arrival is never overwritten by the clear.
            if (cfg_acc && state_q != IDLE) begin
                pending_q  <= 1'b1;
                pend_div_q <= cfg_clamped;
            end
            case (state_q)
                IDLE: begin
                    count_q   <= '0;
                    out_clk_q <= 1'b0;
                    if (pending_q) begin
                        active_div_q <= pend_div_q;
                        pending_q    <= 1'b0;
                    end
                    if (cfg_acc) active_div_q <= cfg_clamped;
                    if (start && !stop) begin
                        state_q     <= RUN;
                        burst_rem_q <= burst_len;
                    end
                end
                RUN: begin
                    count_q   <= toggle ? '0 : count_q + 1'b1;
                    out_clk_q <= out_clk_q ^ toggle;
                    if (boundary) begin
                        if (pending_q) begin
                            active_div_q <= pend_div_q;
                            pending_q    <= 1'b0;
                        end
                        if (burst_rem_q != '0) burst_rem_q <= burst_rem_q - 1'b1;
                        if (burst_rem_q == CNT_WIDTH'(1)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else if (stop) begin
                            state_q <= IDLE;
                        end
                    end else if (stop && !out_clk_q) begin
                        // Truncate the low phase; no high pulse has started yet
                        state_q   <= IDLE;
                        count_q   <= '0;
                        out_clk_q <= 1'b0;
                    end else if (stop) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    count_q   <= toggle ? '0 : count_q + 1'b1;
                    out_clk_q <= out_clk_q ^ toggle;
                    if (toggle) begin
                        state_q <= IDLE;
                        if (pending_q) begin
                            active_div_q <= pend_div_q;
                            pending_q    <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
